// File: rtl/wallace_mac_accumulator.sv
// Dot-product accumulator behind the pipelined Wallace multiplier: carries a valid/last
// tag alongside each operand pair and sums the products as their tags emerge.
module wallace_mac_accumulator #(
    parameter int LATENCY = 13,
    parameter int PROD_W  = 32,
    parameter int ACC_W   = 40,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              abort,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic [CNT_W-1:0]  count_out,
    output logic              overflow,
    output logic              busy
);

    // Tag pipeline: stage LATENCY lines up with the multiplier output.
    logic [LATENCY:1] vld_pipe;
    logic [LATENCY:1] lst_pipe;
    logic             tap_vld;
    logic             tap_lst;
    logic             tap_done;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic [ACC_W:0]   sum;

    assign tap_vld  = vld_pipe[LATENCY];
    assign tap_lst  = lst_pipe[LATENCY];
    assign tap_done = tap_vld & tap_lst;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            vld_pipe <= '0;
            lst_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            lst_pipe[1] <= in_valid & in_last;
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                lst_pipe[i] <= lst_pipe[i-1];
            end
        end
    end

    // One extra bit catches the carry out; once saturated the group stays pinned at all-ones.
    always_comb begin
        sum     = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        ovf_nxt = sum[ACC_W] | ovf;
        acc_nxt = ovf_nxt ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (tap_vld) begin
            if (tap_lst) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt_nxt;
                ovf <= ovf_nxt;
            end
        end
    end

    // Result registers hold across abort so the last good group stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out   <= '0;
            count_out <= '0;
            overflow  <= 1'b0;
            acc_valid <= 1'b0;
        end else if (abort) begin
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= tap_done;
            if (tap_done) begin
                acc_out   <= acc_nxt;
                count_out <= cnt_nxt;
                overflow  <= ovf_nxt;
            end
        end
    end

    assign busy = (|vld_pipe) | (cnt != '0);

endmodule

// File: tb/tb_wallace_mac_accumulator.sv
// Directed bench: models the 13-stage multiplier as a product delay line and checks
// group results, pulse timing, saturation, abort and reset behaviour.
module tb_wallace_mac_accumulator;
    localparam int LAT = 13;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_last, abort;
    logic [15:0] a, b;
    logic [31:0] prod;
    logic [39:0] acc_out;
    logic        acc_valid;
    logic [15:0] count_out;
    logic        overflow, busy;

    logic [31:0] mp [1:LAT];
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int          cyc;
        logic [39:0] acc;
        logic [15:0] cnt;
        logic        ovf;
    } pulse_t;
    pulse_t pq[$];

    wallace_mac_accumulator #(.LATENCY(LAT), .PROD_W(32), .ACC_W(40), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .abort(abort),
        .prod(prod), .acc_out(acc_out), .acc_valid(acc_valid), .count_out(count_out),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the multiplier: operands sampled at an edge appear on prod LAT cycles later.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        mp[1] <= {16'b0, a} * {16'b0, b};
        for (int i = 2; i <= LAT; i++) mp[i] <= mp[i-1];
    end
    assign prod = mp[LAT];

    always @(negedge clk) begin
        if (acc_valid === 1'b1) pq.push_back('{cyc, acc_out, count_out, overflow});
    end

    task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic v, input logic l);
        @(negedge clk);
        a = av; b = bv; in_valid = v; in_last = l;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(16'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        tests++; if (acc_out !== 40'd0) begin fails++; $display("FAIL reset_acc_out: got %0h expected 0", acc_out); end
        tests++; if (count_out !== 16'd0) begin fails++; $display("FAIL reset_count_out: got %0d expected 0", count_out); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        tests++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL reset_acc_valid: got %b expected 0", acc_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int t;
        pq.delete();
        drive(16'd3, 16'd4, 1'b1, 1'b0);
        t = cyc;
        drive(16'd5, 16'd6, 1'b1, 1'b1);
        idle(20);
        tests++; if (pq.size() != 1) begin fails++; $display("FAIL basic_pulses: got %0d expected 1", pq.size()); end
        if (pq.size() >= 1) begin
            tests++; if (pq[0].cyc != t + 15) begin fails++; $display("FAIL basic_latency: got cycle %0d expected %0d", pq[0].cyc, t + 15); end
            tests++; if (pq[0].acc !== 40'd42) begin fails++; $display("FAIL basic_acc: got %0d expected 42", pq[0].acc); end
            tests++; if (pq[0].cnt !== 16'd2) begin fails++; $display("FAIL basic_cnt: got %0d expected 2", pq[0].cnt); end
            tests++; if (pq[0].ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %b expected 0", pq[0].ovf); end
        end
    endtask

    task automatic test_single_max();
        int t;
        pq.delete();
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        t = cyc;
        idle(1);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_inflight: got %b expected 1", busy); end
        idle(19);
        tests++; if (pq.size() != 1) begin fails++; $display("FAIL single_pulses: got %0d expected 1", pq.size()); end
        if (pq.size() >= 1) begin
            tests++; if (pq[0].cyc != t + 14) begin fails++; $display("FAIL single_latency: got cycle %0d expected %0d", pq[0].cyc, t + 14); end
            tests++; if (pq[0].acc !== 40'hFFFE0001) begin fails++; $display("FAIL single_acc: got %0h expected fffe0001", pq[0].acc); end
            tests++; if (pq[0].cnt !== 16'd1) begin fails++; $display("FAIL single_cnt: got %0d expected 1", pq[0].cnt); end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_saturate();
        pq.delete();
        for (int i = 0; i < 300; i++) drive(16'hFFFF, 16'hFFFF, 1'b1, i == 299);
        idle(20);
        tests++; if (pq.size() != 1) begin fails++; $display("FAIL sat_pulses: got %0d expected 1", pq.size()); end
        if (pq.size() >= 1) begin
            tests++; if (pq[0].acc !== 40'hFF_FFFF_FFFF) begin fails++; $display("FAIL sat_acc: got %0h expected ffffffffff", pq[0].acc); end
            tests++; if (pq[0].cnt !== 16'd300) begin fails++; $display("FAIL sat_cnt: got %0d expected 300", pq[0].cnt); end
            tests++; if (pq[0].ovf !== 1'b1) begin fails++; $display("FAIL sat_ovf: got %b expected 1", pq[0].ovf); end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        pq.delete();
        drive(16'd2, 16'd2, 1'b1, 1'b1);
        t = cyc;
        drive(16'd7, 16'd3, 1'b1, 1'b1);
        idle(20);
        tests++; if (pq.size() != 2) begin fails++; $display("FAIL b2b_pulses: got %0d expected 2", pq.size()); end
        if (pq.size() >= 2) begin
            tests++; if (pq[0].cyc != t + 14 || pq[1].cyc != t + 15) begin fails++; $display("FAIL b2b_timing: got cycles %0d,%0d expected %0d,%0d", pq[0].cyc, pq[1].cyc, t + 14, t + 15); end
            tests++; if (pq[0].acc !== 40'd4 || pq[0].cnt !== 16'd1) begin fails++; $display("FAIL b2b_first: got acc %0d cnt %0d expected 4,1", pq[0].acc, pq[0].cnt); end
            tests++; if (pq[1].acc !== 40'd21 || pq[1].cnt !== 16'd1) begin fails++; $display("FAIL b2b_second: got acc %0d cnt %0d expected 21,1", pq[1].acc, pq[1].cnt); end
            tests++; if (pq[0].ovf !== 1'b0) begin fails++; $display("FAIL b2b_ovf_cleared: got %b expected 0", pq[0].ovf); end
        end
    endtask

    task automatic test_gapped();
        pq.delete();
        drive(16'd1, 16'd1, 1'b1, 1'b0);
        idle(2);
        drive(16'd2, 16'd2, 1'b1, 1'b1);
        idle(20);
        tests++; if (pq.size() != 1) begin fails++; $display("FAIL gap_pulses: got %0d expected 1", pq.size()); end
        if (pq.size() >= 1) begin
            tests++; if (pq[0].acc !== 40'd5) begin fails++; $display("FAIL gap_acc: got %0d expected 5", pq[0].acc); end
            tests++; if (pq[0].cnt !== 16'd2) begin fails++; $display("FAIL gap_cnt: got %0d expected 2", pq[0].cnt); end
        end
    endtask

    task automatic test_abort();
        pq.delete();
        for (int i = 0; i < 3; i++) drive(16'd1, 16'd1, 1'b1, 1'b0);
        // Abort cycle also carries a valid last pair, which must be dropped.
        drive(16'd9, 16'd9, 1'b1, 1'b1);
        abort = 1'b1;
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        abort = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
        idle(20);
        tests++; if (pq.size() != 0) begin fails++; $display("FAIL abort_pulses: got %0d expected 0", pq.size()); end
        tests++; if (acc_out !== 40'd5 || count_out !== 16'd2) begin fails++; $display("FAIL abort_hold: got acc %0d cnt %0d expected 5,2", acc_out, count_out); end

        // Abort arriving on the completing tap wins.
        drive(16'd4, 16'd4, 1'b1, 1'b1);
        idle(LAT);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        idle(5);
        tests++; if (pq.size() != 0) begin fails++; $display("FAIL abort_priority: got %0d pulses expected 0", pq.size()); end
        tests++; if (acc_out !== 40'd5) begin fails++; $display("FAIL abort_priority_hold: got %0d expected 5", acc_out); end

        drive(16'd2, 16'd3, 1'b1, 1'b1);
        idle(20);
        tests++; if (pq.size() != 1) begin fails++; $display("FAIL abort_fresh_pulses: got %0d expected 1", pq.size()); end
        tests++; if (acc_out !== 40'd6 || count_out !== 16'd1) begin fails++; $display("FAIL abort_fresh: got acc %0d cnt %0d expected 6,1", acc_out, count_out); end
    endtask

    task automatic test_rst_mid();
        pq.delete();
        for (int i = 0; i < 3; i++) drive(16'd5, 16'd5, 1'b1, 1'b0);
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(20);
        tests++; if (pq.size() != 0) begin fails++; $display("FAIL rst_mid_pulses: got %0d expected 0", pq.size()); end
        tests++; if (acc_out !== 40'd0 || count_out !== 16'd0 || overflow !== 1'b0) begin fails++; $display("FAIL rst_mid_outputs: got acc %0d cnt %0d ovf %b expected 0,0,0", acc_out, count_out, overflow); end
        tests++; if (busy !== 1'b0 || acc_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_busy_valid: got busy %b valid %b expected 0,0", busy, acc_valid); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; abort = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_single_max();
        test_saturate();
        test_back_to_back();
        test_gapped();
        test_abort();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
